cvt_rr_scheduler: RTL and testbench
===================================

// Module: cvt_rr_scheduler
// PURPOSE
//  Shares one hp_cvtsw int->float converter among NREQ requesters.
//  Round-robin arbitration over valid/ready request ports; a 3-state FSM registers the chosen operand,
//  captures the converter result, and holds a tagged response until the consumer accepts it.
//  Keeps sticky inexact/overflow flags for a status register.
// PARAMETERS
//  NREQ  4   number of requesters (>=2)
//  INTn  32  signed integer operand width
//  NEXP  8   float exponent width (passed to hp_cvtsw)
//  NSIG  7   float significand width (passed to hp_cvtsw)
//  IDW   $clog2(NREQ)  requester-id width (localparam)
// PORTS
//  clk            in   1            clock, all state on rising edge
//  rst_n          in   1            async active-low reset
//  req_valid      in   NREQ         per-requester operand valid
//  req_ready      out  NREQ         per-requester accept, one-hot or zero
//  req_data       in   NREQ*INTn    operands; requester k at [k*INTn +: INTn]
//  rsp_valid      out  1            response valid
//  rsp_ready      in   1            consumer accept
//  rsp_data       out  NEXP+NSIG+1  converted float
//  rsp_id         out  IDW          index of requester that owns rsp_data
//  rsp_inexact    out  1            inexact flag of this result
//  rsp_overflow   out  1            overflow flag of this result
//  flag_clr       in   1            clear sticky flags (1-cycle pulse)
//  flag_inexact   out  1            sticky OR of rsp_inexact since clear
//  flag_overflow  out  1            sticky OR of rsp_overflow since clear
//  busy           out  1            FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; rr pointer=0; rsp_valid=0; rsp_data/rsp_id/rsp_inexact/rsp_overflow=0;
//   flag_*=0; internal operand reg=0. A reset mid-operation discards the in-flight operand; no response is produced.
//  States:
//   IDLE: req_ready is combinational. It is one-hot on the granted requester: the first k with req_valid[k],
//    searching ptr, ptr+1, ... modulo NREQ. On |req_valid: latch req_data[k] and id k,
//    set ptr<=(k+1)%NREQ, go to CONV. With no valid request, stay in IDLE.
//   CONV: converter sees the registered operand; register its out/inexact/overflow into rsp_*.
//    Set rsp_valid<=1 and go to RESP. req_ready=0.
//   RESP: rsp_* held stable while rsp_valid=1 && !rsp_ready. On rsp_ready: rsp_valid<=0, go to IDLE.
//    req_ready=0.
//  Latency: request handshake at edge N -> rsp_valid=1 from edge N+2. Peak throughput is 1 per 3 cycles.
//  req_ready is never asserted outside IDLE, and never for a requester whose req_valid=0.
//  Requesters may drop req_valid without a handshake; the arbiter does not remember them.
//  Fairness: with all NREQ valid continuously, grants rotate 0,1,..,NREQ-1,0. No requester waits
//   more than NREQ-1 other grants.
//  Sticky flags update on the rsp handshake cycle: flag_x <= (flag_x & ~flag_clr) | (hs & rsp_x).
//   When set and clear fall in the same cycle, set wins.
//  Operand 0 converts to all-zero, exact. Negative operands give sign=1 with the magnitude of the two's complement.
//   INT_MIN is handled as magnitude 2^(INTn-1).
//  Every result equals the hp_cvtsw output for the latched operand, bit-for-bit.
// TESTING
//  1. Reset, then req0 data=1 -> rsp_data=0x3F80, id=0, inexact=0, rsp_valid exactly 2 cycles after handshake.
//  2. Requesters 0..3 hold valid with data -1,0,257,0x7FFFFFFF, rsp_ready=1 -> ids 0,1,2,3 in order.
//     rsp_data 0xBF80,0x0000,0x4380(inexact),0x4F00(inexact).
//  3. rsp_ready=0 for 5 cycles in RESP -> rsp_data/id stable, req_ready=0, busy=1. Accepted on the cycle rsp_ready rises.
//  4. Data 0x80000000 -> 0xCF00, exact. After test 2, flag_inexact=1. flag_clr alone clears it.
//     flag_clr on the same cycle as an inexact handshake leaves it 1.
//  5. Assert rst_n=0 while in CONV -> rsp_valid=0 immediately. No response after release. Next grant goes to req0.
//  6. Only req2 valid, ptr=3 -> grant wraps to req2. A later req1+req3 request goes to req3 (ptr=3).

Source files
------------

// File: rtl/cvt_rr_if.sv
// Request/response bundle between the requesters, the response consumer and
// the shared int->float converter scheduler.
interface cvt_rr_if #(
   parameter int NREQ = 4,
   parameter int INTn = 32,
   parameter int NEXP = 8,
   parameter int NSIG = 7
);
   localparam int IDW = $clog2(NREQ);
   localparam int FW  = NEXP + NSIG + 1;

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*INTn-1:0] req_data;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [FW-1:0]        rsp_data;
   logic [IDW-1:0]       rsp_id;
   logic                 rsp_inexact;
   logic                 rsp_overflow;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_inexact, rsp_overflow
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_inexact, rsp_overflow
   );
endinterface

// File: rtl/cvt_rr_scheduler.sv
// Shared signed-int -> float converter with a round-robin front end.
// hp_cvtsw: combinational converter, round-to-nearest-even, saturates to
// infinity on exponent overflow. cvt_rr_scheduler: arbiter + 3-state FSM
// (IDLE -> CONV -> RESP) holding a tagged response until accepted.

module hp_cvtsw #(
   parameter int INTn = 32,
   parameter int NEXP = 8,
   parameter int NSIG = 7
) (
   input  logic [INTn-1:0]      din,
   output logic [NEXP+NSIG:0]   out,
   output logic                 inexact,
   output logic                 overflow
);
   localparam int BIAS = (1 << (NEXP - 1)) - 1;
   localparam int EMAX = (1 << NEXP) - 1;

   logic            sgn;
   logic [INTn-1:0] mag;
   logic [INTn-1:0] norm;
   logic [NSIG-1:0] frac;
   logic            guard;
   logic            sticky;
   logic            up;
   logic [NSIG:0]   man_r;
   logic [31:0]     e;
   int              p;

   // Normalize the magnitude, round to nearest even, detect overflow.
   always_comb begin
      sgn = din[INTn-1];
      // Unsigned negation: INT_MIN becomes 2^(INTn-1) naturally.
      mag = sgn ? -din : din;
      p = 0;
      for (int i = 0; i < INTn; i++)
         if (mag[i]) p = i;
      norm   = mag << (INTn - 1 - p);
      frac   = norm[INTn-2 -: NSIG];
      guard  = norm[INTn-2-NSIG];
      sticky = 1'b0;
      for (int i = 0; i < INTn - 2 - NSIG; i++)
         sticky = sticky | norm[i];
      up       = guard & (sticky | frac[0]);
      man_r    = {1'b0, frac} + {{NSIG{1'b0}}, up};
      // Carry out of the rounded fraction bumps the exponent; fraction is then zero.
      e        = 32'(BIAS + p) + {31'b0, man_r[NSIG]};
      inexact  = guard | sticky;
      overflow = 1'b0;
      out      = {sgn, e[NEXP-1:0], man_r[NSIG-1:0]};
      if (e >= 32'(EMAX)) begin
         overflow = 1'b1;
         inexact  = 1'b1;
         out      = {sgn, {NEXP{1'b1}}, {NSIG{1'b0}}};
      end
      if (mag == '0) begin
         out      = '0;
         inexact  = 1'b0;
         overflow = 1'b0;
      end
   end
endmodule

module cvt_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int INTn = 32,
   parameter int NEXP = 8,
   parameter int NSIG = 7
) (
   input  logic     clk,
   input  logic     rst_n,
   cvt_rr_if.slave  bus,
   input  logic     flag_clr,
   output logic     flag_inexact,
   output logic     flag_overflow,
   output logic     busy
);
   localparam int IDW = $clog2(NREQ);
   localparam int FW  = NEXP + NSIG + 1;

   typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  id_q;
   logic [INTn-1:0] op_q;
   logic [IDW-1:0]  gnt_id;
   logic            gnt_found;
   int              arb_idx;
   logic [FW-1:0]   cv_out;
   logic            cv_inexact;
   logic            cv_overflow;
   logic            rsp_hs;

   hp_cvtsw #(.INTn(INTn), .NEXP(NEXP), .NSIG(NSIG)) u_cvt (
      .din      (op_q),
      .out      (cv_out),
      .inexact  (cv_inexact),
      .overflow (cv_overflow)
   );

   // Round-robin pick: first valid requester at or after ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      arb_idx   = 0;
      for (int i = 0; i < NREQ; i++) begin
         arb_idx = (int'(ptr) + i) % NREQ;
         if (!gnt_found && bus.req_valid[arb_idx]) begin
            gnt_found = 1'b1;
            gnt_id    = IDW'(arb_idx);
         end
      end
   end

   // Grants are only offered while idle; one-hot on the winner.
   assign bus.req_ready = (state == IDLE && gnt_found) ? (NREQ'(1) << gnt_id) : '0;
   assign busy          = (state != IDLE);
   assign rsp_hs        = bus.rsp_valid & bus.rsp_ready;

   // Scheduler FSM: latch winner, capture converter result, hold response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         ptr              <= '0;
         id_q             <= '0;
         op_q             <= '0;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_data     <= '0;
         bus.rsp_id       <= '0;
         bus.rsp_inexact  <= 1'b0;
         bus.rsp_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  op_q  <= bus.req_data[gnt_id*INTn +: INTn];
                  id_q  <= gnt_id;
                  ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               bus.rsp_data     <= cv_out;
               bus.rsp_id       <= id_q;
               bus.rsp_inexact  <= cv_inexact;
               bus.rsp_overflow <= cv_overflow;
               bus.rsp_valid    <= 1'b1;
               state            <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky status flags; a set on the handshake beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_inexact  <= 1'b0;
         flag_overflow <= 1'b0;
      end else begin
         flag_inexact  <= (flag_inexact  & ~flag_clr) | (rsp_hs & bus.rsp_inexact);
         flag_overflow <= (flag_overflow & ~flag_clr) | (rsp_hs & bus.rsp_overflow);
      end
   end
endmodule

// File: tb/tb_cvt_rr_scheduler.sv
// Bench for cvt_rr_scheduler: directed scenarios plus randomized traffic
// against a cycle-level behavioural model with an arithmetic reference converter.
module tb_cvt_rr_scheduler;
   localparam int NREQ = 4;
   localparam int INTn = 32;
   localparam int NEXP = 8;
   localparam int NSIG = 7;
   localparam int BIAS = (1 << (NEXP - 1)) - 1;
   localparam int EMAX = (1 << NEXP) - 1;

   logic clk;
   logic rst_n;
   logic flag_clr;
   logic flag_inexact;
   logic flag_overflow;
   logic busy;

   cvt_rr_if #(.NREQ(NREQ), .INTn(INTn), .NEXP(NEXP), .NSIG(NSIG)) bus ();

   cvt_rr_scheduler #(.NREQ(NREQ), .INTn(INTn), .NEXP(NEXP), .NSIG(NSIG)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .flag_clr      (flag_clr),
      .flag_inexact  (flag_inexact),
      .flag_overflow (flag_overflow),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_fail;

   typedef struct {
      int          id;
      logic [15:0] data;
      logic        inx;
   } rsp_t;
   rsp_t rsp_log[$];

   // model state: stage 0 idle, 1 converting, 2 holding response
   int          m_stage;
   int          m_ptr;
   int          m_id;
   logic [31:0] m_op;
   logic [17:0] m_rsp;
   logic        m_fi;
   logic        m_fo;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {overflow, inexact, float} computed with integer arithmetic
   function automatic logic [17:0] ref_cvt(input logic [31:0] x);
      longint m, q, rem, half;
      int p, sh, e;
      logic s, inx;
      logic [31:0] ev;
      logic [31:0] qv;
      s = x[31];
      m = s ? ((longint'(1) << 32) - longint'(x)) : longint'(x);
      if (m == 0) return '0;
      p = 0;
      while ((m >> (p + 1)) != 0) p++;
      if (p > NSIG) begin
         sh   = p - NSIG;
         q    = m >> sh;
         rem  = m - (q << sh);
         half = longint'(1) << (sh - 1);
         inx  = (rem != 0);
         if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      end else begin
         q   = m << (NSIG - p);
         inx = 1'b0;
      end
      if (q == (longint'(1) << (NSIG + 1))) begin
         q = q >> 1;
         p = p + 1;
      end
      e = BIAS + p;
      if (e >= EMAX) return {1'b1, 1'b1, s, 8'hFF, 7'h00};
      ev = 32'(e);
      qv = 32'(q);
      return {1'b0, inx, s, ev[7:0], qv[6:0]};
   endfunction

   // winner = valid requester at smallest forward distance from the pointer
   function automatic int model_grant(input logic [NREQ-1:0] v);
      int best, bd, d;
      best = -1;
      bd   = NREQ;
      for (int k = 0; k < NREQ; k++) begin
         if (v[k]) begin
            d = (k - m_ptr + NREQ) % NREQ;
            if (d < bd) begin
               bd   = d;
               best = k;
            end
         end
      end
      return best;
   endfunction

   task automatic set_op(input int k, input logic [31:0] v);
      bus.req_data[k*INTn +: INTn] = v;
   endtask

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = $urandom;
         1: v = 32'($urandom_range(0, 300));
         2: v = -32'($urandom_range(1, 300));
         3: v = 32'h8000_0000;
         4: v = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 2)) - 32'd1;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   // One clock: check outputs against the model at negedge, advance both.
   task automatic step();
      int g;
      logic hs;
      logic [NREQ-1:0] exp_rdy;
      @(negedge clk);
      g = model_grant(bus.req_valid);
      exp_rdy = (m_stage == 0 && g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(m_stage != 0));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_stage == 2));
      if (m_stage == 2) begin
         chk("rsp_data", 32'(bus.rsp_data), 32'(m_rsp[15:0]));
         chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
         chk("rsp_inexact", 32'(bus.rsp_inexact), 32'(m_rsp[16]));
         chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(m_rsp[17]));
      end
      chk("flag_inexact", 32'(flag_inexact), 32'(m_fi));
      chk("flag_overflow", 32'(flag_overflow), 32'(m_fo));
      if (bus.rsp_valid && bus.rsp_ready)
         rsp_log.push_back('{int'(bus.rsp_id), bus.rsp_data, bus.rsp_inexact});
      hs   = (m_stage == 2) && bus.rsp_ready;
      m_fi = (m_fi & ~flag_clr) | (hs & m_rsp[16]);
      m_fo = (m_fo & ~flag_clr) | (hs & m_rsp[17]);
      if (m_stage == 0) begin
         if (g >= 0) begin
            m_id    = g;
            m_op    = bus.req_data[g*INTn +: INTn];
            m_ptr   = (g + 1) % NREQ;
            m_stage = 1;
         end
      end else if (m_stage == 1) begin
         m_rsp   = ref_cvt(m_op);
         m_stage = 2;
      end else if (hs) begin
         m_stage = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_stage = 0;
      m_ptr   = 0;
      m_id    = 0;
      m_op    = '0;
      m_rsp   = '0;
      m_fi    = 1'b0;
      m_fo    = 1'b0;
   endtask

   // Called just after a rising edge; returns aligned the same way.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
      chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
      chk({tag, "_rsp_flags"}, 32'({bus.rsp_inexact, bus.rsp_overflow}), 32'd0);
      chk({tag, "_sticky"}, 32'({flag_inexact, flag_overflow}), 32'd0);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic wait_rsp(input string tag);
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 10) begin
         step();
         n++;
      end
      chk({tag, "_wait"}, 32'(bus.rsp_valid), 32'd1);
   endtask

   logic [15:0] t2_data [4];
   logic        t2_inx  [4];
   logic [17:0] r3;
   int          n;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      flag_clr = 1'b0;
      bus.req_valid = '0;
      bus.req_data = '0;
      bus.rsp_ready = 1'b0;
      model_reset();
      apply_reset("reset");

      // 1: single request, latency of two edges
      set_op(0, 32'd1);
      bus.req_valid = 4'b0001;
      #1 chk("t1_ready", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = '0;
      chk("t1_lat1", 32'(bus.rsp_valid), 32'd0);
      step();
      chk("t1_lat2", 32'(bus.rsp_valid), 32'd1);
      chk("t1_data", 32'(bus.rsp_data), 32'h3F80);
      chk("t1_id", 32'(bus.rsp_id), 32'd0);
      chk("t1_inexact", 32'(bus.rsp_inexact), 32'd0);
      bus.rsp_ready = 1'b1;
      step();
      chk("t1_accept", 32'(bus.rsp_valid), 32'd0);

      // 2: all requesters valid, rotation and conversion values
      apply_reset("reset2");
      t2_data = '{16'hBF80, 16'h0000, 16'h4380, 16'h4F00};
      t2_inx  = '{1'b0, 1'b0, 1'b1, 1'b1};
      set_op(0, 32'hFFFF_FFFF);
      set_op(1, 32'h0000_0000);
      set_op(2, 32'd257);
      set_op(3, 32'h7FFF_FFFF);
      bus.req_valid = 4'hF;
      bus.rsp_ready = 1'b1;
      rsp_log.delete();
      n = 0;
      while (rsp_log.size() < 4 && n < 40) begin
         step();
         n++;
      end
      drain();
      chk("t2_count", 32'(rsp_log.size() >= 4), 32'd1);
      if (rsp_log.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_id%0d", i), 32'(rsp_log[i].id), 32'(i));
            chk($sformatf("t2_data%0d", i), 32'(rsp_log[i].data), 32'(t2_data[i]));
            chk($sformatf("t2_inx%0d", i), 32'(rsp_log[i].inx), 32'(t2_inx[i]));
         end
      end

      // 3: consumer back-pressure holds the response
      set_op(1, 32'd12345);
      r3 = ref_cvt(32'd12345);
      bus.req_valid = 4'b0010;
      bus.rsp_ready = 1'b0;
      step();
      bus.req_valid = 4'hF;
      wait_rsp("t3");
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("t3_hold_data", 32'(bus.rsp_data), 32'(r3[15:0]));
         chk("t3_hold_id", 32'(bus.rsp_id), 32'd1);
         chk("t3_ready0", 32'(bus.req_ready), 32'd0);
         chk("t3_busy", 32'(busy), 32'd1);
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      step();
      chk("t3_accept", 32'(bus.rsp_valid), 32'd0);

      // 4: INT_MIN, sticky flag clear and set-wins
      chk("t4_sticky_set", 32'(flag_inexact), 32'd1);
      set_op(0, 32'h8000_0000);
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b0;
      step();
      bus.req_valid = '0;
      step();
      chk("t4_data", 32'(bus.rsp_data), 32'hCF00);
      chk("t4_inexact", 32'(bus.rsp_inexact), 32'd0);
      bus.rsp_ready = 1'b1;
      step();
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("t4_clear", 32'(flag_inexact), 32'd0);
      set_op(2, 32'd257);
      bus.req_valid = 4'b0100;
      bus.rsp_ready = 1'b0;
      step();
      bus.req_valid = '0;
      wait_rsp("t4");
      bus.rsp_ready = 1'b1;
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("t4_set_wins", 32'(flag_inexact), 32'd1);

      // 5: reset during conversion drops the operand
      set_op(1, 32'd5);
      bus.req_valid = 4'b0010;
      step();
      bus.req_valid = '0;
      apply_reset("t5");
      for (int i = 0; i < 4; i++) step();
      chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
      bus.req_valid = 4'hF;
      #1 chk("t5_grant0", 32'(bus.req_ready), 32'h1);
      drain();

      // 6: pointer wrap
      apply_reset("t6");
      bus.req_valid = 4'b0100;
      #1 chk("t6_first", 32'(bus.req_ready), 32'h4);
      step();
      drain();
      bus.req_valid = 4'b0100;
      #1 chk("t6_wrap", 32'(bus.req_ready), 32'h4);
      step();
      drain();
      bus.req_valid = 4'b1010;
      #1 chk("t6_ptr3", 32'(bus.req_ready), 32'h8);
      step();
      drain();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bus.req_valid = NREQ'($urandom_range(0, 15));
         for (int k = 0; k < NREQ; k++)
            if ($urandom_range(0, 1) == 1) set_op(k, rand_op());
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         flag_clr      = ($urandom_range(0, 15) == 0);
         step();
      end
      flag_clr = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
